mdu_issue_ctrl: RTL

Initiator side of the MDU handshake, sitting in the E stage between the decoded instruction and the MDU. It registers MDU requests and drives `start`/`MDUOp`/operands for one cycle. It tracks the in-flight multiply/divide with a shadow latency counter and raises the D-stage stall for any MDU-class instruction until HI/LO are final. It also flags handshake violations where the MDU's `busy` disagrees with the expected latency.

---
 rtl/mdu_pkg.sv | 47 ++++
 rtl/mdu_issue_ctrl_if.sv | 13 +
 rtl/mdu_lat_counter.sv | 25 ++
 rtl/mdu_issue_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU opcode encoding, class decode helpers, issue FSM state and default latencies.
package mdu_pkg;

    localparam int unsigned OP_W        = 4;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned MUL_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF = 10;

    localparam logic [OP_W-1:0] MDU_NONE  = 4'd0;
    localparam logic [OP_W-1:0] MDU_MULT  = 4'd1;
    localparam logic [OP_W-1:0] MDU_MULTU = 4'd2;
    localparam logic [OP_W-1:0] MDU_DIV   = 4'd3;
    localparam logic [OP_W-1:0] MDU_DIVU  = 4'd4;
    localparam logic [OP_W-1:0] MDU_MFHI  = 4'd5;
    localparam logic [OP_W-1:0] MDU_MFLO  = 4'd6;
    localparam logic [OP_W-1:0] MDU_MTHI  = 4'd7;
    localparam logic [OP_W-1:0] MDU_MTLO  = 4'd8;
    localparam logic [OP_W-1:0] MDU_MADD  = 4'd9;
    localparam logic [OP_W-1:0] MDU_MSUB  = 4'd10;
    localparam logic [OP_W-1:0] MDU_SHL   = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2
    } mdu_state_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } mdu_req_t;

    function automatic logic is_mul(input logic [OP_W-1:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_MADD) || (op == MDU_MSUB);
    endfunction

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_move(input logic [OP_W-1:0] op);
        return (op == MDU_MTHI) || (op == MDU_MTLO) || (op == MDU_SHL);
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// Request/busy handshake between the E-stage issue controller and the MDU.
interface mdu_issue_ctrl_if;
    import mdu_pkg::*;

    logic              mdu_start;
    logic [OP_W-1:0]   mdu_op;
    logic [DATA_W-1:0] mdu_a;
    logic [DATA_W-1:0] mdu_b;
    logic              mdu_busy;

    modport master (output mdu_start, output mdu_op, output mdu_a, output mdu_b, input mdu_busy);
    modport slave  (input mdu_start, input mdu_op, input mdu_a, input mdu_b, output mdu_busy);
endinterface

// File: rtl/mdu_lat_counter.sv
// Loadable down-counter that saturates at zero; shadows the MDU's remaining latency.
module mdu_lat_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero_c
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// E-stage MDU issue controller: registers requests, shadows latency, stalls D, flags busy violations.
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              e_valid,
    input  logic [OP_W-1:0]   e_mdu_op,
    input  logic [DATA_W-1:0] e_rs,
    input  logic [DATA_W-1:0] e_rt,
    input  logic              flush,
    input  logic              d_mdu_use,
    mdu_issue_ctrl_if.master  mdu,
    output logic              stall_d,
    output logic              proto_err
);

    mdu_req_t         req_q;
    logic             start_q;
    logic             issue_q;
    mdu_state_e       state_q;
    mdu_state_e       state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] load_val;
    logic             cnt_zero;
    logic             accept;
    logic             pending;
    logic             err_c;

    assign accept   = e_valid && !flush &&
                      (is_mul(e_mdu_op) || is_div(e_mdu_op) || is_move(e_mdu_op));
    assign pending  = !cnt_zero || start_q || (req_q.op != MDU_NONE);
    assign stall_d  = d_mdu_use && pending;
    assign load_val = is_mul(req_q.op) ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);

    mdu_lat_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (start_q),
        .load_val (load_val),
        .cnt      (cnt),
        .zero_c   (cnt_zero)
    );

    // Next state follows the counter; the final count-1 cycle may overlap a new accept.
    always_comb begin
        state_d = ST_IDLE;
        err_c   = 1'b0;
        if (accept) begin
            state_d = ST_ISSUE;
        end else if (start_q || (cnt > CNT_W'(1))) begin
            state_d = ST_RUN;
        end
        if ((state_q == ST_IDLE) && mdu.mdu_busy) begin
            err_c = 1'b1;
        end
        if ((state_q == ST_RUN) && issue_q && !mdu.mdu_busy && (cnt > CNT_W'(1))) begin
            err_c = 1'b1;
        end
        if (accept && (start_q || (req_q.op != MDU_NONE) || (cnt > CNT_W'(1)))) begin
            err_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request register; operands hold while idle, only the op and start return to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q     <= '0;
            start_q   <= 1'b0;
            issue_q   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (accept) begin
                req_q.op <= e_mdu_op;
                req_q.a  <= e_rs;
                req_q.b  <= e_rt;
                start_q  <= is_mul(e_mdu_op) || is_div(e_mdu_op);
            end else begin
                req_q.op <= MDU_NONE;
                start_q  <= 1'b0;
            end
            issue_q <= (state_q == ST_ISSUE);
            if (err_c) begin
                proto_err <= 1'b1;
            end
        end
    end

    assign mdu.mdu_start = start_q;
    assign mdu.mdu_op    = req_q.op;
    assign mdu.mdu_a     = req_q.a;
    assign mdu.mdu_b     = req_q.b;

endmodule
